// File: rtl/aes_ctrl_pkg.sv
// Shared definitions for the AES-128 round sequencer.
//   - state_e         : controller state encoding
//   - SEL_ARK / SEL_ROUNDFB : state mux select values (round-input buffer source)
//   - SEL_KEY_EXT / SEL_KEY_FB : key mux select values (round-key-in buffer source)
//   - AES128_ROUNDS   : number of rounds for AES-128
package aes_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ARK,
        ST_ROUND,
        ST_KEY,
        ST_FINAL,
        ST_DONE
    } state_e;

    localparam logic SEL_ARK     = 1'b0;
    localparam logic SEL_ROUNDFB = 1'b1;
    localparam logic SEL_KEY_EXT = 1'b0;
    localparam logic SEL_KEY_FB  = 1'b1;

    localparam int AES128_ROUNDS = 10;

endpackage

// File: rtl/aes128_round_sequencer.sv
// Moore controller for the iterative AES-128 cipher datapath, with a
// valid/ready request interface on the input and on the result.
//
// Ports:
//   clk        in   rising-edge clock
//   reset      in   asynchronous active-low reset
//   in_valid   in   host presents message/key
//   in_ready   out  block can be accepted this cycle
//   out_valid  out  ciphertext buffer holds an untaken result
//   out_ready  in   host takes the result
//   ld_msg     out  message buffer enable
//   ld_key     out  round-key-in buffer enable
//   sel_key    out  key mux select (0 external key, 1 expanded-key feedback)
//   en_state   out  round-input buffer enable
//   sel_state  out  state mux select (0 AddRoundKey result, 1 RoundBlock feedback)
//   en_round   out  RoundBlock output buffer enable
//   en_out     out  ciphertext buffer enable
//   en_rkey    out  expanded-key buffer enable
//   round_idx  out  KeyExpansion round number (Rcon index), 0 when en_rkey is low
//   busy       out  block in flight
//
// Timeline for one block (E0 = accepting edge): en_rkey captures at the odd
// edges E1..E(2N-1) with round_idx 1..N, en_round at the even edges
// E2..E(2N-2), en_out at E(2N), after which out_valid is held until taken.
module aes128_round_sequencer
    import aes_ctrl_pkg::*;
#(
    parameter int NUM_ROUNDS = AES128_ROUNDS,
    parameter int RIDX_W     = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              ld_msg,
    output logic              ld_key,
    output logic              sel_key,
    output logic              en_state,
    output logic              sel_state,
    output logic              en_round,
    output logic              en_out,
    output logic              en_rkey,
    output logic [RIDX_W-1:0] round_idx,
    output logic              busy
);

    localparam logic [RIDX_W-1:0] RIDX_ONE  = RIDX_W'(1);
    localparam logic [RIDX_W-1:0] RIDX_LAST = RIDX_W'(NUM_ROUNDS);

    state_e            state_q, state_d;
    logic [RIDX_W-1:0] r_q, r_d;
    logic [RIDX_W-1:0] r_next;
    logic              accept;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            r_q     <= '0;
        end else begin
            state_q <= state_d;
            r_q     <= r_d;
        end
    end

    // r counts completed KeyExpansion steps; r+1 is the round being expanded.
    assign r_next = r_q + 1'b1;

    always_comb begin
        state_d   = state_q;
        r_d       = r_q;
        accept    = 1'b0;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        ld_msg    = 1'b0;
        ld_key    = 1'b0;
        sel_key   = SEL_KEY_EXT;
        en_state  = 1'b0;
        sel_state = SEL_ARK;
        en_round  = 1'b0;
        en_out    = 1'b0;
        en_rkey   = 1'b0;
        round_idx = '0;

        unique case (state_q)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    accept  = 1'b1;
                    r_d     = RIDX_ONE;
                    state_d = ST_ARK;
                end
            end
            ST_ARK: begin
                en_state  = 1'b1;
                sel_state = SEL_ARK;
                en_rkey   = 1'b1;
                round_idx = RIDX_ONE;
                state_d   = ST_ROUND;
            end
            ST_ROUND: begin
                en_round = 1'b1;
                ld_key   = 1'b1;
                sel_key  = SEL_KEY_FB;
                state_d  = ST_KEY;
            end
            ST_KEY: begin
                en_state  = 1'b1;
                sel_state = SEL_ROUNDFB;
                en_rkey   = 1'b1;
                round_idx = r_next;
                if (r_next == RIDX_LAST) begin
                    state_d = ST_FINAL;
                end else begin
                    r_d     = r_next;
                    state_d = ST_ROUND;
                end
            end
            ST_FINAL: begin
                en_out  = 1'b1;
                state_d = ST_DONE;
            end
            ST_DONE: begin
                out_valid = 1'b1;
                // Taking the result frees the pipeline, so a new block can be
                // accepted on the same edge without passing through IDLE.
                in_ready  = out_ready;
                if (out_ready) begin
                    if (in_valid) begin
                        accept  = 1'b1;
                        r_d     = RIDX_ONE;
                        state_d = ST_ARK;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Loading message and external key is the handshake itself; sel_key
        // stays at the external source since accept never occurs in ROUND.
        ld_msg = accept;
        if (accept) begin
            ld_key = 1'b1;
        end
    end

    assign busy = (state_q != ST_IDLE) && (state_q != ST_DONE);

endmodule

// File: tb/tb_aes128_round_sequencer.sv
module tb_aes128_round_sequencer;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic in_valid = 1'b0;
    logic out_ready = 1'b0;

    logic       rdy10, ov10, ldm10, ldk10, selk10, ens10, sels10, enr10, eno10, enk10, busy10;
    logic [3:0] idx10;
    logic       rdy4, ov4, ldm4, ldk4, selk4, ens4, sels4, enr4, eno4, enk4, busy4;
    logic [3:0] idx4;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    always #5 clk = ~clk;

    aes128_round_sequencer #(.NUM_ROUNDS(10), .RIDX_W(4)) dut10 (
        .clk(clk), .reset(rst_n), .in_valid(in_valid), .in_ready(rdy10),
        .out_valid(ov10), .out_ready(out_ready), .ld_msg(ldm10), .ld_key(ldk10),
        .sel_key(selk10), .en_state(ens10), .sel_state(sels10), .en_round(enr10),
        .en_out(eno10), .en_rkey(enk10), .round_idx(idx10), .busy(busy10)
    );

    aes128_round_sequencer #(.NUM_ROUNDS(4), .RIDX_W(4)) dut4 (
        .clk(clk), .reset(rst_n), .in_valid(in_valid), .in_ready(rdy4),
        .out_valid(ov4), .out_ready(out_ready), .ld_msg(ldm4), .ld_key(ldk4),
        .sel_key(selk4), .en_state(ens4), .sel_state(sels4), .en_round(enr4),
        .en_out(eno4), .en_rkey(enk4), .round_idx(idx4), .busy(busy4)
    );

    // Packed views: {in_ready, out_valid, ld_msg, ld_key, sel_key, en_state,
    // sel_state, en_round, en_out, en_rkey, busy, round_idx[3:0]}
    wire [14:0] act10 = {rdy10, ov10, ldm10, ldk10, selk10, ens10, sels10, enr10, eno10, enk10, busy10, idx10};
    wire [14:0] act4  = {rdy4, ov4, ldm4, ldk4, selk4, ens4, sels4, enr4, eno4, enk4, busy4, idx4};
    localparam logic [14:0] IDLE_VEC = 15'h4000;

    // Reference model: k = -1 idle, 0..2n-1 = cycles since acceptance, 2n = result held.
    int k10 = -1;
    int k4  = -1;

    function automatic logic [14:0] exp_vec(int k, int n, logic iv, logic ordy);
        logic ark, rnd, key, fin, done, idle, rdy, ld, bsy;
        int   idx;
        idle = (k < 0);
        ark  = (k == 0);
        rnd  = (k >= 1) && (k <= 2*n-2) && (k % 2 == 1);
        key  = (k >= 2) && (k <= 2*n-2) && (k % 2 == 0);
        fin  = (k == 2*n-1);
        done = (k == 2*n);
        bsy  = (k >= 0) && (k < 2*n);
        rdy  = idle | (done & ordy);
        ld   = iv & rdy;
        idx  = ark ? 1 : (key ? (k/2 + 1) : 0);
        return {rdy, done, ld, ld | rnd, rnd, ark | key, key, rnd, fin, ark | key, bsy, 4'(idx)};
    endfunction

    function automatic int next_k(int k, int n, logic iv, logic ordy);
        if (k < 0)      return iv ? 0 : -1;
        if (k < 2*n)    return k + 1;
        if (ordy)       return iv ? 0 : -1;
        return k;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            k10 <= -1;
            k4  <= -1;
        end else begin
            k10 <= next_k(k10, 10, in_valid, out_ready);
            k4  <= next_k(k4, 4, in_valid, out_ready);
        end
    end

    task automatic check(input string name, input logic [14:0] act, input logic [14:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s cyc=%0d: got %h want %h", name, cyc, act, expv);
        end
    endtask

    task automatic check_int(input string name, input int act, input int expv);
        total++;
        if (act != expv) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", name, act, expv);
        end
    endtask

    // One clock: compare both DUTs with the model mid-cycle, then advance.
    task automatic tick();
        @(negedge clk);
        check("model10", act10, exp_vec(k10, 10, in_valid, out_ready));
        check("model4", act4, exp_vec(k4, 4, in_valid, out_ready));
        @(posedge clk);
        #1;
        cyc++;
    endtask

    typedef struct {
        logic       iv;
        logic       ordy;
        logic       rdy;
        logic       ov;
        logic       ld;
        logic       rkey;
        logic [3:0] idx;
        logic       rnd;
        logic       eout;
        logic       busy;
    } vec_t;

    vec_t tbl[12];

    initial begin
        int first, second, n;

        // One block through the NUM_ROUNDS=4 instance, cycle by cycle.
        tbl[0]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0};
        tbl[1]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd1, 1'b0, 1'b0, 1'b1};
        tbl[2]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 1'b1};
        tbl[3]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd2, 1'b0, 1'b0, 1'b1};
        tbl[4]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 1'b1};
        tbl[5]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd3, 1'b0, 1'b0, 1'b1};
        tbl[6]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 1'b1};
        tbl[7]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd4, 1'b0, 1'b0, 1'b1};
        tbl[8]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b1, 1'b1};
        tbl[9]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0};
        tbl[10] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0};
        tbl[11] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0};

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("reset10", act10, IDLE_VEC);
        check("reset4", act4, IDLE_VEC);
        rst_n = 1'b1;
        tick();

        // Table-driven single block on the short instance
        for (int i = 0; i < 12; i++) begin
            in_valid  = tbl[i].iv;
            out_ready = tbl[i].ordy;
            #1;
            total++;
            if ({rdy4, ov4, ldm4, enk4, idx4, enr4, eno4, busy4} !==
                {tbl[i].rdy, tbl[i].ov, tbl[i].ld, tbl[i].rkey, tbl[i].idx, tbl[i].rnd, tbl[i].eout, tbl[i].busy}) begin
                bad++;
                $display("FAIL table4 row=%0d: got %b want %b", i,
                         {rdy4, ov4, ldm4, enk4, idx4, enr4, eno4, busy4},
                         {tbl[i].rdy, tbl[i].ov, tbl[i].ld, tbl[i].rkey, tbl[i].idx, tbl[i].rnd, tbl[i].eout, tbl[i].busy});
            end
            tick();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (25) tick();

        // Hold the result 50 cycles with out_ready low; in_valid must be ignored.
        in_valid  = 1'b1;
        out_ready = 1'b0;
        tick();
        in_valid = 1'b0;
        n = 0;
        while (!ov10 && n < 40) begin
            tick();
            n++;
        end
        check_int("latency_hold", n, 20);
        for (int i = 0; i < 50; i++) begin
            in_valid = 1'($urandom_range(0, 1));
            tick();
        end
        check_int("hold_out_valid", int'(ov10), 1);
        check_int("hold_in_ready", int'(rdy10), 0);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        tick();

        // Back-to-back accepts: ciphertext captures 2N+1 cycles apart
        in_valid  = 1'b1;
        out_ready = 1'b1;
        first = -1;
        second = -1;
        for (int i = 0; i < 80 && second < 0; i++) begin
            if (eno10) begin
                if (first < 0) first = cyc;
                else second = cyc;
            end
            tick();
        end
        check_int("b2b_gap10", second - first, 21);
        first = -1;
        second = -1;
        for (int i = 0; i < 40 && second < 0; i++) begin
            if (eno4) begin
                if (first < 0) first = cyc;
                else second = cyc;
            end
            tick();
        end
        check_int("b2b_gap4", second - first, 9);

        // Abort mid-block with reset
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (25) tick();
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (9) tick();
        rst_n = 1'b0;
        #1;
        check("abort10", act10, IDLE_VEC);
        check("abort4", act4, IDLE_VEC);
        tick();
        rst_n = 1'b1;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        n = 0;
        while (!ov10 && n < 40) begin
            tick();
            n++;
        end
        check_int("latency_after_abort", n, 20);

        // Randomized traffic against the model
        for (int i = 0; i < 800; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) == 0);
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/aes128_round_sequencer.md
Name: aes128_round_sequencer

Overview:
- Moore-style controller that sequences the iterative AES-128 cipher datapath: message/key buffers, initial AddRoundKey, state and key feedback muxes, RoundBlock, KeyExpansion and LastBlock output buffer.
- Replaces the free-running fsm with a valid/ready request interface, so a host can issue one block at a time and hold the result until it is consumed.
- Drives every buffer enable, both mux selects and the KeyExpansion round index (keyInit).

Parameters:
- NUM_ROUNDS, 10, total AES rounds including the final round. Legal range 2..15.
- RIDX_W, 4, width of round_idx; must hold NUM_ROUNDS.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- in_valid  in  1  host presents message/key for a new block.
- in_ready  out  1  sequencer can accept a block this cycle.
- out_valid  out  1  ciphertext buffer holds a result not yet taken.
- out_ready  in  1  host takes the result.
- ld_msg  out  1  message buffer enable (buffer1en).
- ld_key  out  1  round-key-in buffer enable (buffer2en).
- sel_key  out  1  key mux select: 0 = external key, 1 = expanded-key feedback (sel2).
- en_state  out  1  round-input buffer enable (buffer3en).
- sel_state  out  1  state mux select: 0 = AddRoundKey result, 1 = RoundBlock feedback (sel).
- en_round  out  1  RoundBlock output buffer enable (buffer4en).
- en_out  out  1  ciphertext buffer enable (buffer5en).
- en_rkey  out  1  expanded-key buffer enable (buffer6en).
- round_idx  out  RIDX_W  round number for KeyExpansion Rcon (keyInit).
- busy  out  1  block in flight (any state other than IDLE or DONE).

Behaviour:
- Reset (async assert, sync deassert by the system) forces IDLE, round counter 0, and all outputs 0 except in_ready = 1.
- States are IDLE, ARK, ROUND, KEY, FINAL and DONE. All outputs decode from the state, except ld_msg/ld_key, which are in_valid & in_ready.
- IDLE: in_ready = 1. On in_valid, assert ld_msg and ld_key with sel_key = 0, set r = 1, go to ARK.
- ARK: en_state = 1 with sel_state = 0; en_rkey = 1 with round_idx = 1. Go to ROUND.
- ROUND: en_round = 1, and ld_key = 1 with sel_key = 1. Go to KEY.
- KEY: en_state = 1 with sel_state = 1; en_rkey = 1 with round_idx = r+1. If r+1 == NUM_ROUNDS go to FINAL, else increment r and go to ROUND.
- FINAL: en_out = 1. Go to DONE.
- DONE: out_valid = 1; the result stays stable until out_ready. On out_ready, leave DONE.
- Back-to-back: in DONE, in_ready = out_ready. If in_valid and out_ready are both high, accept the new block that cycle and go directly to ARK. Otherwise out_ready returns to IDLE.
- Latency: the accepting edge is E0, the en_out capture edge is E(2*NUM_ROUNDS), and out_valid is high from that edge. That is 20 cycles for AES-128. Throughput is 1 block per 21 cycles with back-to-back accepts.
- round_idx is 0 in every state that does not assert en_rkey.
- In IDLE, in_ready stays high and out_valid low, regardless of out_ready.
- In_valid is ignored while busy; no queuing.
- Reset asserted mid-block aborts immediately: state IDLE, enables 0. Datapath buffer contents are don't-care afterwards.
- Never assert two enables onto the same buffer in one cycle. Never assert en_out outside FINAL.

Decomposition:
- Shared package aes_ctrl_pkg holds:
  - the state enum;
  - constants SEL_ARK = 0, SEL_ROUNDFB = 1, SEL_KEY_EXT = 0, SEL_KEY_FB = 1;
  - AES128_ROUNDS = 10.
- No sub-module: the round counter and FSM live in one module.
- The top-level cipher instantiates this block in place of fsm and adds the four handshake ports.

Test Plan:
- Reset then a single request: in_valid pulse at E0 gives ld_msg/ld_key/sel_key = 0 at E0. Expect en_rkey at E1, 3, 5, …, 19 with round_idx 1, 2, …, 10; en_round at E2, 4, …, 18; en_out only at E20; out_valid from E20.
- Integrated with the datapath, key 000102…0f and plaintext 00112233445566778899aabbccddeeff: crypte = 69c4e0d86a7b0430d8cdb78070b4c55a when out_valid.
- Hold out_ready low 50 cycles after done: out_valid stays 1, in_ready stays 0, ciphertext unchanged, in_valid ignored.
- In DONE with out_ready = 1 and in_valid = 1 in the same cycle: new block accepted, state ARK. Second ciphertext 21 cycles after the first; no gap state.
- Assert reset at E9 mid-block: in the same cycle busy = 0, all enables 0, round_idx = 0. After release, a fresh request completes in 20 cycles.
- NUM_ROUNDS = 4 instance: en_out at E8, round_idx sequence 1..4, out_valid at E8.
